// File: rtl/execute_ctl_hs_if.sv
// Handshake and bus bundle between decode/regfile, the execute control register and execute.
interface execute_ctl_hs_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] data_a;
  logic [XLEN-1:0] data_b;
  logic [XLEN-1:0] pc_de;
  logic [31:0]     instruction;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      a_sel;
  logic            b_sel;
  logic [3:0]      imm_sel;
  logic [3:0]      alu_sel;
  logic            sign;
  logic [2:0]      br_expect;
  logic            illegal;
  logic [XLEN-1:0] data_a_exe;
  logic [XLEN-1:0] data_b_exe;
  logic [XLEN-1:0] pc_exe;
  logic [31:0]     instr_exe;

  modport slave (
    input  in_valid, data_a, data_b, pc_de, instruction, flush, out_ready,
    output in_ready, out_valid, a_sel, b_sel, imm_sel, alu_sel, sign, br_expect,
           illegal, data_a_exe, data_b_exe, pc_exe, instr_exe
  );

  modport master (
    output in_valid, data_a, data_b, pc_de, instruction, flush, out_ready,
    input  in_ready, out_valid, a_sel, b_sel, imm_sel, alu_sel, sign, br_expect,
           illegal, data_a_exe, data_b_exe, pc_exe, instr_exe
  );
endinterface

// File: rtl/execute_ctl_hs.sv
// ID/EX control register with valid/ready handshakes, flush and a multi-cycle WAIT state.
// Define EXE_CTL_MEXT_EN to decode RV32M and hold issue for MUL_LAT/DIV_LAT cycles.
module execute_ctl_hs #(
  parameter int          XLEN      = 32,
  parameter int          MUL_LAT   = 2,
  parameter int          DIV_LAT   = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic              clk,
  input logic              rst_n,
  execute_ctl_hs_if.slave  bus
);
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [3:0] ALU_BUB  = 4'b0110;

  if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
    $error("execute_ctl_hs: MUL_LAT and DIV_LAT must be >= 1");
  end

`ifdef EXE_CTL_MEXT_EN
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dec_mul, dec_div;
`endif

  logic [1:0]      state_q, state_d;
  logic [1:0]      a_sel_q, a_sel_d, dec_a_sel;
  logic            b_sel_q, b_sel_d, dec_b_sel;
  logic [3:0]      imm_sel_q, imm_sel_d, dec_imm_sel;
  logic [3:0]      alu_sel_q, alu_sel_d, dec_alu_sel;
  logic            sign_q, sign_d, dec_sign;
  logic [2:0]      br_expect_q, br_expect_d, dec_br_expect;
  logic            illegal_q, illegal_d;
  logic            dec_legal;
  logic [XLEN-1:0] data_a_exe_q, data_a_exe_d, data_b_exe_q, data_b_exe_d;
  logic [XLEN-1:0] pc_exe_q, pc_exe_d;
  logic [31:0]     instr_exe_q, instr_exe_d;
  logic            in_ready, accept, load, bubble;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = bus.instruction[6:0];
  assign funct3 = bus.instruction[14:12];
  assign funct7 = bus.instruction[31:25];

  always_comb begin
    dec_a_sel     = 2'd0;
    dec_b_sel     = 1'b1;
    dec_imm_sel   = 4'd0;
    dec_alu_sel   = ALU_BUB;
    dec_sign      = 1'b0;
    dec_br_expect = 3'd0;
    dec_legal     = 1'b1;
`ifdef EXE_CTL_MEXT_EN
    dec_mul       = 1'b0;
    dec_div       = 1'b0;
`endif
    case (opcode)
      7'b0110111: dec_imm_sel = 4'd4;
      7'b0010111: begin dec_a_sel = 2'd1; dec_imm_sel = 4'd4; dec_alu_sel = 4'b0011; end
      7'b1101111: begin
        dec_a_sel = 2'd1; dec_imm_sel = 4'd5; dec_alu_sel = 4'b0011; dec_sign = 1'b1;
      end
      7'b1100111: begin
        dec_imm_sel = 4'd1; dec_alu_sel = 4'b0011; dec_sign = 1'b1;
        dec_legal = (funct3 == 3'b000);
      end
      7'b1100011: begin
        dec_a_sel = 2'd1; dec_imm_sel = 4'd3; dec_alu_sel = 4'b0011;
        case (funct3)
          3'b000:  dec_br_expect = 3'd1;
          3'b001:  dec_br_expect = 3'd2;
          3'b100:  dec_br_expect = 3'd3;
          3'b101:  dec_br_expect = 3'd4;
          3'b110:  dec_br_expect = 3'd5;
          3'b111:  dec_br_expect = 3'd6;
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        dec_imm_sel = 4'd1; dec_alu_sel = 4'b0011;
        case (funct3)
          3'b000, 3'b001, 3'b010: dec_sign = 1'b1;
          3'b100, 3'b101:         dec_sign = 1'b0;
          default:                dec_legal = 1'b0;
        endcase
      end
      7'b0100011: begin
        dec_imm_sel = 4'd2; dec_alu_sel = 4'b0011; dec_sign = 1'b1;
        dec_legal = (funct3 <= 3'b010);
      end
      7'b0010011: begin
        dec_imm_sel = 4'd1;
        case (funct3)
          3'b000: begin dec_alu_sel = 4'b0011; dec_sign = 1'b1; end
          3'b010: dec_alu_sel = 4'b1100;
          3'b011: dec_alu_sel = 4'b1011;
          3'b100: begin dec_alu_sel = 4'b0010; dec_sign = 1'b1; end
          3'b110: begin dec_alu_sel = 4'b0001; dec_sign = 1'b1; end
          3'b111: begin dec_alu_sel = 4'b0000; dec_sign = 1'b1; end
          3'b001: begin dec_alu_sel = 4'b0111; dec_legal = (funct7 == 7'b0000000); end
          default: begin
            if (funct7 == 7'b0000000)      dec_alu_sel = 4'b1000;
            else if (funct7 == 7'b0100000) dec_alu_sel = 4'b1010;
            else                           dec_legal = 1'b0;
          end
        endcase
      end
      7'b0110011: begin
        dec_b_sel = 1'b0;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_alu_sel = 4'b0011;
            3'b001:  dec_alu_sel = 4'b0111;
            3'b010:  dec_alu_sel = 4'b1100;
            3'b011:  dec_alu_sel = 4'b1011;
            3'b100:  dec_alu_sel = 4'b0010;
            3'b101:  dec_alu_sel = 4'b1000;
            3'b110:  dec_alu_sel = 4'b0001;
            default: dec_alu_sel = 4'b0000;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_alu_sel = 4'b0100;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec_alu_sel = 4'b1010;
`ifdef EXE_CTL_MEXT_EN
        end else if (funct7 == 7'b0000001) begin
          // MUL variant stays recoverable from funct3 in instr_exe
          dec_mul     = ~funct3[2];
          dec_div     = funct3[2];
          dec_alu_sel = funct3[2] ? 4'b1110 : 4'b1101;
`endif
        end else begin
          dec_legal = 1'b0;
        end
      end
      7'b0001111: begin dec_alu_sel = 4'b0000; dec_b_sel = 1'b0; dec_legal = (funct3 == 3'b000); end
      7'b1110011: begin
        dec_alu_sel = 4'b0000; dec_b_sel = 1'b0;
        dec_legal = (bus.instruction == 32'h0000_0073) || (bus.instruction == 32'h0010_0073);
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_a_sel = 2'd0; dec_b_sel = 1'b0; dec_imm_sel = 4'd0; dec_alu_sel = 4'b0000;
      dec_sign = 1'b0; dec_br_expect = 3'd0;
`ifdef EXE_CTL_MEXT_EN
      dec_mul = 1'b0; dec_div = 1'b0;
`endif
    end
  end

  assign in_ready = (state_q == ST_EMPTY) || (state_q == ST_FULL && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    load    = 1'b0;
    bubble  = 1'b0;
    state_d = state_q;
`ifdef EXE_CTL_MEXT_EN
    cnt_d   = cnt_q;
`endif
    if (bus.flush) begin
      bubble  = 1'b1;
      state_d = ST_EMPTY;
`ifdef EXE_CTL_MEXT_EN
      cnt_d   = '0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: load = accept;
        ST_FULL: begin
          if (bus.out_ready) begin
            load = accept;
            if (!accept) begin
              bubble  = 1'b1;
              state_d = ST_EMPTY;
            end
          end
        end
`ifdef EXE_CTL_MEXT_EN
        ST_WAIT: begin
          if (cnt_q == '0) state_d = ST_FULL;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
`endif
        default: begin
          bubble  = 1'b1;
          state_d = ST_EMPTY;
        end
      endcase
      if (load) begin
        state_d = ST_FULL;
`ifdef EXE_CTL_MEXT_EN
        if (dec_mul && MUL_LAT > 1) begin
          state_d = ST_WAIT;
          cnt_d   = MUL_CNT;
        end else if (dec_div && DIV_LAT > 1) begin
          state_d = ST_WAIT;
          cnt_d   = DIV_CNT;
        end
`endif
      end
    end
  end

  always_comb begin
    a_sel_d      = a_sel_q;
    b_sel_d      = b_sel_q;
    imm_sel_d    = imm_sel_q;
    alu_sel_d    = alu_sel_q;
    sign_d       = sign_q;
    br_expect_d  = br_expect_q;
    illegal_d    = illegal_q;
    data_a_exe_d = data_a_exe_q;
    data_b_exe_d = data_b_exe_q;
    pc_exe_d     = pc_exe_q;
    instr_exe_d  = instr_exe_q;
    if (bubble) begin
      a_sel_d = 2'd0; b_sel_d = 1'b1; imm_sel_d = 4'd0; alu_sel_d = ALU_BUB;
      sign_d = 1'b0; br_expect_d = 3'd0; illegal_d = 1'b0;
      data_a_exe_d = '0; data_b_exe_d = '0; pc_exe_d = '0; instr_exe_d = NOP_INSTR;
    end else if (load) begin
      a_sel_d = dec_a_sel; b_sel_d = dec_b_sel; imm_sel_d = dec_imm_sel;
      alu_sel_d = dec_alu_sel; sign_d = dec_sign; br_expect_d = dec_br_expect;
      illegal_d = ~dec_legal;
      data_a_exe_d = bus.data_a; data_b_exe_d = bus.data_b;
      pc_exe_d = bus.pc_de; instr_exe_d = bus.instruction;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      a_sel_q      <= 2'd0;
      b_sel_q      <= 1'b1;
      imm_sel_q    <= 4'd0;
      alu_sel_q    <= ALU_BUB;
      sign_q       <= 1'b0;
      br_expect_q  <= 3'd0;
      illegal_q    <= 1'b0;
      data_a_exe_q <= '0;
      data_b_exe_q <= '0;
      pc_exe_q     <= '0;
      instr_exe_q  <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      a_sel_q      <= a_sel_d;
      b_sel_q      <= b_sel_d;
      imm_sel_q    <= imm_sel_d;
      alu_sel_q    <= alu_sel_d;
      sign_q       <= sign_d;
      br_expect_q  <= br_expect_d;
      illegal_q    <= illegal_d;
      data_a_exe_q <= data_a_exe_d;
      data_b_exe_q <= data_b_exe_d;
      pc_exe_q     <= pc_exe_d;
      instr_exe_q  <= instr_exe_d;
    end
  end

`ifdef EXE_CTL_MEXT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state_q == ST_FULL);
  assign bus.a_sel      = a_sel_q;
  assign bus.b_sel      = b_sel_q;
  assign bus.imm_sel    = imm_sel_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.sign       = sign_q;
  assign bus.br_expect  = br_expect_q;
  assign bus.illegal    = illegal_q;
  assign bus.data_a_exe = data_a_exe_q;
  assign bus.data_b_exe = data_b_exe_q;
  assign bus.pc_exe     = pc_exe_q;
  assign bus.instr_exe  = instr_exe_q;
endmodule

// File: tb/tb_execute_ctl_hs.sv
// Directed bench for execute_ctl_hs: occupancy/latency model plus spot literal checks.
module tb_execute_ctl_hs;
  localparam int XLEN = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 8;

  typedef struct packed {
    logic [1:0] a;
    logic       b;
    logic [3:0] imm;
    logic [3:0] alu;
    logic       s;
    logic [2:0] br;
    logic       ill;
    logic [7:0] lat;
  } dec_t;

  localparam logic [3:0] ALU_F3 [8] = '{4'b0011, 4'b0111, 4'b1100, 4'b1011,
                                        4'b0010, 4'b1000, 4'b0001, 4'b0000};
  localparam dec_t BUB = '{a: 2'd0, b: 1'b1, imm: 4'd0, alu: 4'b0110, s: 1'b0,
                           br: 3'd0, ill: 1'b0, lat: 8'd1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  execute_ctl_hs_if #(.XLEN(XLEN)) bus ();
  execute_ctl_hs #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT),
                   .NOP_INSTR(32'h0000_0013)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    d = BUB; f3 = w[14:12]; f7 = w[31:25]; ok = 1'b1;
    case (w[6:0])
      7'h37: d.imm = 4'd4;
      7'h17: begin d.a = 2'd1; d.imm = 4'd4; d.alu = 4'd3; end
      7'h6f: begin d.a = 2'd1; d.imm = 4'd5; d.alu = 4'd3; d.s = 1'b1; end
      7'h67: begin d.imm = 4'd1; d.alu = 4'd3; d.s = 1'b1; ok = (f3 == 3'd0); end
      7'h63: begin
        d.a = 2'd1; d.imm = 4'd3; d.alu = 4'd3;
        if (f3 == 3'd2 || f3 == 3'd3) ok = 1'b0;
        else d.br = (f3 < 3'd2) ? f3 + 3'd1 : f3 - 3'd1;
      end
      7'h03: begin d.imm = 4'd1; d.alu = 4'd3; ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; d.s = (f3 < 3'd3); end
      7'h23: begin d.imm = 4'd2; d.alu = 4'd3; d.s = 1'b1; ok = (f3 < 3'd3); end
      7'h13: begin
        d.imm = 4'd1; d.alu = ALU_F3[f3]; d.s = f3 inside {3'd0, 3'd4, 3'd6, 3'd7};
        if (f3 == 3'd1) ok = (f7 == 7'd0);
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) d.alu = 4'b1010;
          else ok = (f7 == 7'd0);
        end
      end
      7'h33: begin
        d.b = 1'b0;
        if (f7 == 7'd0) d.alu = ALU_F3[f3];
        else if (f7 == 7'h20) begin
          if (f3 == 3'd0) d.alu = 4'b0100;
          else if (f3 == 3'd5) d.alu = 4'b1010;
          else ok = 1'b0;
        end
`ifdef EXE_CTL_MEXT_EN
        else if (f7 == 7'h01) begin
          d.alu = f3[2] ? 4'b1110 : 4'b1101;
          d.lat = f3[2] ? 8'(DIV_LAT) : 8'(MUL_LAT);
        end
`endif
        else ok = 1'b0;
      end
      7'h0f: begin d.alu = 4'd0; d.b = 1'b0; ok = (f3 == 3'd0); end
      7'h73: begin d.alu = 4'd0; d.b = 1'b0; ok = (w == 32'h73) || (w == 32'h0010_0073); end
      default: ok = 1'b0;
    endcase
    if (!ok) d = '{a: 2'd0, b: 1'b0, imm: 4'd0, alu: 4'd0, s: 1'b0, br: 3'd0, ill: 1'b1, lat: 8'd1};
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: an op is either absent, waiting out its latency, or presented.
  logic            m_full = 1'b0;
  int              m_wait = 0;
  dec_t            m_ctl = BUB;
  logic [XLEN-1:0] m_da = '0, m_db = '0, m_pc = '0;
  logic [31:0]     m_ins = 32'h13;
  logic            m_rdy, m_acc;
  dec_t            m_dec;

  assign m_rdy = (!m_full && m_wait == 0) || (m_full && bus.out_ready);
  assign m_acc = bus.in_valid && m_rdy;
  assign m_dec = ref_dec(bus.instruction);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.flush) begin
      m_full <= 1'b0; m_wait <= 0; m_ctl <= BUB;
      m_da <= '0; m_db <= '0; m_pc <= '0; m_ins <= 32'h13;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_full <= 1'b1;
    end else if (m_acc) begin
      m_ctl <= m_dec; m_da <= bus.data_a; m_db <= bus.data_b;
      m_pc <= bus.pc_de; m_ins <= bus.instruction;
      if (m_dec.lat > 8'd1) begin m_wait <= int'(m_dec.lat); m_full <= 1'b0; end
      else m_full <= 1'b1;
    end else if (m_full && bus.out_ready) begin
      m_full <= 1'b0; m_ctl <= BUB;
      m_da <= '0; m_db <= '0; m_pc <= '0; m_ins <= 32'h13;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("sb_in_ready", 64'(bus.in_ready), 64'(m_rdy));
      check("sb_out_valid", 64'(bus.out_valid), 64'(m_full));
      check("sb_a_sel", 64'(bus.a_sel), 64'(m_ctl.a));
      check("sb_b_sel", 64'(bus.b_sel), 64'(m_ctl.b));
      check("sb_imm_sel", 64'(bus.imm_sel), 64'(m_ctl.imm));
      check("sb_alu_sel", 64'(bus.alu_sel), 64'(m_ctl.alu));
      check("sb_sign", 64'(bus.sign), 64'(m_ctl.s));
      check("sb_br_expect", 64'(bus.br_expect), 64'(m_ctl.br));
      check("sb_illegal", 64'(bus.illegal), 64'(m_ctl.ill));
      check("sb_data_a", 64'(bus.data_a_exe), 64'(m_da));
      check("sb_data_b", 64'(bus.data_b_exe), 64'(m_db));
      check("sb_pc", 64'(bus.pc_exe), 64'(m_pc));
      check("sb_instr", 64'(bus.instr_exe), 64'(m_ins));
    end
  end

  task automatic cyc(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    bus.in_valid = v; bus.instruction = ins; bus.out_ready = ordy; bus.flush = fl;
    bus.data_a = $urandom; bus.data_b = $urandom; bus.pc_de = $urandom & 32'hFFFF_FFFC;
    @(posedge clk); #1;
  endtask

  task automatic chk_bubble(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_alu"}, 64'(bus.alu_sel), 64'h6);
    check({tag, "_b_sel"}, 64'(bus.b_sel), 64'd1);
    check({tag, "_instr"}, 64'(bus.instr_exe), 64'h13);
  endtask

  localparam int NV = 22;
  localparam logic [31:0] VEC [NV] = '{
    32'h000012B7, 32'h00001297, 32'h008000EF, 32'h000080E7, 32'h0000A103, 32'h0000C103,
    32'h0020A023, 32'h0050A093, 32'h4010D093, 32'h4020D0B3, 32'h0020B0B3, 32'h0000000F,
    32'h00000073, 32'h00100073, 32'h30001073, 32'h0020A463, 32'h0020D463, 32'h0020E463,
    32'h022080B3, 32'h0220C0B3, 32'h40309093, 32'hFFF0C093};

  initial begin
    bus.in_valid = 0; bus.instruction = 32'h13; bus.out_ready = 1; bus.flush = 0;
    bus.data_a = '0; bus.data_b = '0; bus.pc_de = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_bubble("reset");
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    cyc(1, 32'h00500093, 1, 0);
    check("addi_alu", 64'(bus.alu_sel), 64'h3);
    check("addi_imm", 64'(bus.imm_sel), 64'd1);
    check("addi_sign", 64'(bus.sign), 64'd1);
    cyc(1, 32'h00208463, 1, 0);
    check("beq_a_sel", 64'(bus.a_sel), 64'd1);
    check("beq_imm", 64'(bus.imm_sel), 64'd3);
    check("beq_br", 64'(bus.br_expect), 64'd1);
    check("beq_in_ready", 64'(bus.in_ready), 64'd1);
    cyc(0, 32'h13, 1, 0);

    cyc(1, 32'h402081B3, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'h002081B3, 0, 0);
      check("bp_alu", 64'(bus.alu_sel), 64'h4);
      check("bp_b_sel", 64'(bus.b_sel), 64'd0);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_instr", 64'(bus.instr_exe), 64'h402081B3);
    end
    cyc(1, 32'h002081B3, 1, 0);
    check("bp_release_instr", 64'(bus.instr_exe), 64'h002081B3);
    check("bp_release_alu", 64'(bus.alu_sel), 64'h3);

    cyc(1, 32'hFFF0C093, 1, 1);
    chk_bubble("flush");
    cyc(0, 32'h13, 1, 0);
    check("flush_drop", 64'(bus.out_valid), 64'd0);

    cyc(1, 32'hFFFFFFFF, 1, 0);
    check("illegal_flag", 64'(bus.illegal), 64'd1);
    check("illegal_valid", 64'(bus.out_valid), 64'd1);
    check("illegal_alu", 64'(bus.alu_sel), 64'h0);
    cyc(0, 32'h13, 1, 0);

    for (int i = 0; i < NV; i++) begin
      int tries;
      logic took;
      tries = 0; took = 1'b0;
      while (!took && tries < 20) begin
        bus.in_valid = 1; bus.instruction = VEC[i]; bus.out_ready = (tries % 3) != 1; bus.flush = 0;
        bus.data_a = $urandom; bus.data_b = $urandom; bus.pc_de = $urandom & 32'hFFFF_FFFC;
        @(negedge clk); took = bus.in_ready;
        @(posedge clk); #1;
        tries++;
      end
      if (!took) check("accept_bound", 64'd0, 64'd1);
    end
    repeat (12) cyc(0, 32'h13, 1, 0);

`ifdef EXE_CTL_MEXT_EN
    cyc(1, 32'h0220C0B3, 1, 0);
    for (int k = 0; k < 8; k++) begin
      check("div_wait_in_ready", 64'(bus.in_ready), 64'd0);
      check("div_wait_valid", 64'(bus.out_valid), 64'd0);
      cyc(1, 32'h00500093, 1, 0);
    end
    check("div_done_valid", 64'(bus.out_valid), 64'd1);
    check("div_done_alu", 64'(bus.alu_sel), 64'hE);
    cyc(0, 32'h13, 1, 0);
    cyc(0, 32'h13, 1, 0);

    cyc(1, 32'h0220C0B3, 1, 0);
    repeat (3) cyc(0, 32'h13, 1, 0);
    cyc(0, 32'h13, 1, 1);
    chk_bubble("div_flush");
    check("div_flush_in_ready", 64'(bus.in_ready), 64'd1);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 32'h13, 1, 0);
      check("div_flush_quiet", 64'(bus.out_valid), 64'd0);
    end

    cyc(1, 32'h022080B3, 1, 0);
    check("mul_wait", 64'(bus.out_valid), 64'd0);
    cyc(0, 32'h13, 0, 0);
    check("mul_wait2", 64'(bus.out_valid), 64'd0);
    cyc(0, 32'h13, 0, 0);
    check("mul_done_alu", 64'(bus.alu_sel), 64'hD);
    check("mul_done_valid", 64'(bus.out_valid), 64'd1);
    cyc(0, 32'h13, 1, 0);

    cyc(1, 32'h0220C0B3, 1, 0);
    cyc(0, 32'h13, 1, 0);
`else
    cyc(1, 32'h022080B3, 1, 0);
    check("mul_illegal_flag", 64'(bus.illegal), 64'd1);
    check("mul_illegal_valid", 64'(bus.out_valid), 64'd1);
    cyc(1, 32'h00500093, 0, 0);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk_bubble("midop_reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) cyc(0, 32'h13, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
